// File: rtl/nibble_serial_add_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl_pkg
//
// Shared definitions for the nibble-serial add/subtract controller:
//   - state_t     : controller FSM encoding (IDLE / RUN / DONE)
//   - NIB_W       : width of one adder pass (one nibble)
//   - width_legal : elaboration-time legality test for the operand width
// ----------------------------------------------------------------------------
package nibble_serial_add_ctrl_pkg;

  // Width of the shared adder slice; everything is processed in units of this.
  localparam int NIB_W = 4;

  // Controller states. Encodings are fixed so that debug probes and any
  // external decode of the state bits stay stable across revisions.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // An operand width is usable only if it splits into whole nibbles and
  // contains at least one of them.
  function automatic bit width_legal(input int w);
    return (w >= NIB_W) && ((w % NIB_W) == 0);
  endfunction

endpackage : nibble_serial_add_ctrl_pkg

// File: rtl/nibble_serial_add_ctrl_ripple_carry.sv
// ----------------------------------------------------------------------------
// ripple_carry
//
// Purely combinational NIB_W-bit ripple-carry adder. The serial controller
// owns exactly one instance and time-multiplexes it across the operand
// nibbles.
//
// Ports:
//   a    in   NIB_W  addend A
//   b    in   NIB_W  addend B
//   cin  in   1      carry in
//   s    out  NIB_W  sum
//   cout out  1      carry out of the top bit
// ----------------------------------------------------------------------------
module ripple_carry
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  // The carry chain is a procedural variable rather than a vector of nets so
  // each stage's carry is a distinct value in the combinational graph instead
  // of a vector that appears to feed back on itself.
  logic carry;

  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule : ripple_carry

// File: rtl/nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Computes a WIDTH-bit a+b or a-b using a single shared 4-bit ripple-carry
// adder, one nibble per clock, LSB nibble first. The carry between nibbles
// is held in a register. Operands are taken with a valid/ready handshake and
// the result is offered with a valid/ready handshake.
//
// Subtraction is done as a + ~b + 1: the inverted B is stored at accept and
// the +1 enters as the initial carry.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      operands present
//   in_ready  out  1      controller can accept operands (IDLE only)
//   a         in   WIDTH  operand A (unsigned or two's complement)
//   b         in   WIDTH  operand B
//   sub       in   1      0: a+b, 1: a-b
//   out_valid out  1      result available (DONE only)
//   out_ready in   1      consumer accepts result
//   sum       out  WIDTH  result, modulo 2^WIDTH
//   cout      out  1      final carry; for subtract 1 means no borrow
//   ovf       out  1      signed two's-complement overflow
// ----------------------------------------------------------------------------
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if (!width_legal(WIDTH)) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH=%0d must be a multiple of %0d and >= %0d",
             WIDTH, NIB_W, NIB_W);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  logic [IDX_W-1:0]              idx_reg;
  logic                          carry_reg;
  // Operands and result are kept as nibble arrays so the current pass can be
  // selected by a plain index.
  logic [NIBBLES-1:0][NIB_W-1:0] a_reg;
  logic [NIBBLES-1:0][NIB_W-1:0] b_reg;
  logic [NIBBLES-1:0][NIB_W-1:0] sum_reg;
  logic                          cout_reg;
  logic                          ovf_reg;

  // Shared adder connections
  logic [NIB_W-1:0] add_a;
  logic [NIB_W-1:0] add_b;
  logic [NIB_W-1:0] add_s;
  logic             add_cout;

  // Handshake / sequencing strobes
  logic accept;
  logic fire_out;
  logic last_nib;

  assign accept   = in_valid  && in_ready;
  assign fire_out = out_valid && out_ready;
  assign last_nib = (state_reg == RUN) && (idx_reg == LAST_IDX);

  // --------------------------------------------------------------------------
  // The one shared adder slice
  // --------------------------------------------------------------------------
  assign add_a = a_reg[idx_reg];
  assign add_b = b_reg[idx_reg];

  ripple_carry u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_reg),
    .s    (add_s),
    .cout (add_cout)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept)   state_next = RUN;
      RUN:  if (last_nib) state_next = DONE;
      // No new accept from DONE even when the result leaves this cycle; the
      // controller always passes back through IDLE.
      DONE: if (fire_out) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (Moore; depends on state only)
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_reg)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, nibble index, carry, result accumulation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            // Subtract as a + ~b + 1; the +1 arrives as the first carry in.
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            idx_reg   <= '0;
            sum_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx_reg] <= add_s;
          carry_reg        <= add_cout;
          if (idx_reg == LAST_IDX) begin
            idx_reg  <= '0;
            cout_reg <= add_cout;
            // Overflow when both effective addends share a sign and the top
            // nibble's sign bit disagrees with it. b_reg is already inverted
            // for subtract, so one rule covers both operations.
            ovf_reg  <= (a_reg[NIBBLES-1][NIB_W-1] == b_reg[NIBBLES-1][NIB_W-1]) &&
                        (add_s[NIB_W-1] != a_reg[NIBBLES-1][NIB_W-1]);
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;  // DONE: hold result stable until it is taken
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule : nibble_serial_add_ctrl

// File: tb/tb_nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//
// Directed bench for nibble_serial_add_ctrl (WIDTH=16). Expected results are
// queued when operands are offered and popped when the result handshake
// completes. Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  logic [WIDTH-1:0] rx;
  logic [WIDTH-1:0] ry;
  logic             rs;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s);
    exp_t e;
    int   sx;
    int   sy;
    int   res;
    logic [WIDTH:0] u;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    res = s ? (sx - sy) : (sx + sy);
    e.ovf = (res > 32767) || (res < -32768);
    if (s) begin
      u      = {1'b0, x} - {1'b0, y};
      e.cout = (x >= y);
    end else begin
      u      = {1'b0, x} + {1'b0, y};
      e.cout = u[WIDTH];
    end
    e.sum = u[WIDTH-1:0];
    return e;
  endfunction

  // Offer operands (from a falling edge), returning on the falling edge after
  // the accepting rising edge. Inputs are then scrambled to show they are not
  // re-sampled.
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a        = x;
    b        = y;
    sub      = s;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    sub      = 1'($urandom);
    check("in_ready_in_run", in_ready, 0);
  endtask

  // Wait (bounded) for out_valid; the count of rising edges since accept must
  // equal the number of nibbles.
  task automatic wait_done();
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, NIBBLES);
    check("out_valid_done", out_valid, 1);
  endtask

  // Compare against the scoreboard and complete the output handshake.
  task automatic finish_op();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check("sum",  sum,  e.sum);
    check("cout", cout, e.cout);
    check("ovf",  ovf,  e.ovf);
    $display("txn: sum=%04h cout=%0b ovf=%0b (expect %04h %0b %0b)",
             sum, cout, ovf, e.sum, e.cout, e.ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_take", out_valid, 0);
    check("in_ready_after_take",  in_ready,  1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum",       sum,       0);
    check("rst_cout",      cout,      0);
    check("rst_ovf",       ovf,       0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    start_op(16'h1234, 16'h0FFF, 1'b0, mk(16'h2233, 1'b0, 1'b0)); wait_done(); finish_op();
    start_op(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0)); wait_done(); finish_op();
    start_op(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0)); wait_done(); finish_op();
    start_op(16'h0007, 16'h0005, 1'b1, mk(16'h0002, 1'b1, 1'b0)); wait_done(); finish_op();
    start_op(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1)); wait_done(); finish_op();
    start_op(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1)); wait_done(); finish_op();

    // Backpressure: result held in DONE while new operands are pulsed
    start_op(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0));
    wait_done();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      sub      = 1'($urandom);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready,  0);
      check("bp_sum",       sum,       16'h3333);
    end
    in_valid = 1'b0;
    finish_op();

    // Reset in the middle of RUN; the next operation must see no old carry
    start_op(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_run_out_valid", out_valid, 0);
    check("rst_run_sum",       sum,       0);
    check("rst_run_in_ready",  in_ready,  1);
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h0001, 16'h0001, 1'b0, mk(16'h0002, 1'b0, 1'b0)); wait_done(); finish_op();

    // Reset while a result is waiting in DONE: out_valid drops without a clock
    start_op(16'h1234, 16'h0FFF, 1'b0, mk(16'h2233, 1'b0, 1'b0));
    wait_done();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_sum",       sum,       0);
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // A few random operations against the integer model
    for (int i = 0; i < 8; i++) begin
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      rs = 1'($urandom);
      start_op(rx, ry, rs, model(rx, ry, rs));
      wait_done();
      finish_op();
    end

    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_nibble_serial_add_ctrl

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencing controller that computes WIDTH-bit add/subtract through one shared 4-bit ripple_carry adder instance.
- Processes one nibble per clock, LSB first. The carry is registered between nibbles.
- Valid/ready on both input and output sides; sits between an operand producer and a result consumer.
- Trades latency for area versus a full-width adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIBBLES, WIDTH/4, derived number of adder passes; not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- sub  input  1  0: a+b, 1: a-b
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  final carry; for sub, 1 = no borrow (a>=b unsigned)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; idx=0; carry_reg=0.
  - sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 (decoded from IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: a_reg<=a; b_reg<=sub ? ~b : b; carry_reg<=sub; idx<=0; clear sum; go to RUN.
- RUN, one nibble per cycle:
  - in_ready=0.
  - Adder inputs: A=a_reg[4*idx+:4], B=b_reg[4*idx+:4], Cin=carry_reg.
  - Each edge: sum[4*idx+:4]<=S; carry_reg<=Cout; idx<=idx+1.
  - On the edge where idx==NIBBLES-1: cout<=adder Cout; ovf<=(a_reg[MSB]==b_reg[MSB]) && (S[3]!=a_reg[MSB]); go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum/cout/ovf held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE and drop out_valid next cycle.
- Latency: accept at edge k, out_valid high after edge k+NIBBLES. WIDTH=4 gives 1 RUN cycle.
- Throughput: one operation per NIBBLES+2 cycles minimum; no accept while in DONE, even if out_ready=1.
- Operands and sub are sampled only at accept. Later changes on a/b/sub have no effect.
- in_valid during RUN/DONE is ignored (in_ready=0); the producer holds it per valid/ready rules.
- Width rules:
  - sum is modulo 2^WIDTH.
  - Intermediate sum nibbles may be observed during RUN but are valid only with out_valid.
- Reset mid-RUN or mid-DONE: operation discarded, out_valid falls immediately, carry_reg cleared; no stale carry reaches the next operation.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - NIB_W=4;
  - the WIDTH%4 legality check macro/function.
- One sub-module: a single instance of the existing ripple_carry 4-bit adder.
- FSM, nibble index counter, operand/result registers and overflow logic live in nibble_serial_add_ctrl.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0FFF, sub=0 -> sum=0x2233, cout=0, ovf=0; out_valid asserted exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 registered nibble passes).
- a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> sum/out_valid stable, in_ready=0, new operands not captured; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: drop rst_n after 2 RUN cycles of 0xFFFF+0x0001 -> out_valid=0 and sum=0 immediately; after release, 0x0001+0x0001 -> sum=0x0002, cout=0 (no leaked carry).
